// File: rtl/rv_ifetch.sv
// Instruction-fetch alignment stage: turns halfword-aligned core fetches into word-aligned
// memory reads, stitching word-straddling instructions from a one-word line buffer.
module rv_ifetch #(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] i_adr,
    input  logic          i_re,
    output logic [31:0]   i_dr,
    output logic          i_rdy,
    output logic [AW-1:0] m_adr,
    output logic          m_re,
    input  logic [31:0]   m_dr,
    input  logic          m_rdy,
    output logic [15:0]   n_split
);

    localparam int unsigned WW = AW - 2;

    typedef enum logic [1:0] {
        K_FULL = 2'd0,
        K_LOW  = 2'd1,
        K_HIGH = 2'd2
    } kind_t;

    logic          ret_v;
    kind_t         ret_kind;
    logic [WW-1:0] ret_word;
    logic          stall_v;
    kind_t         stall_kind;
    logic [WW-1:0] stall_word;
    logic [WW-1:0] req_word;
    logic [31:0]   buf_q;
    logic [WW-1:0] tag_q;
    logic          valid_q;
    logic [15:0]   split_q;

    logic          idle;
    logic          sample;
    logic [WW-1:0] sample_word;
    logic          eff_valid;
    logic [WW-1:0] eff_tag;
    kind_t         new_kind;
    logic [WW-1:0] new_word;
    logic          iss_v;
    kind_t         iss_kind;
    logic [WW-1:0] iss_word;
    logic          unused_adr0;

    assign unused_adr0 = i_adr[0];
    assign sample_word = i_adr[AW-1:2];

    // A return in flight is about to overwrite the buffer, so classify against its tag.
    assign eff_valid = ret_v | valid_q;
    assign eff_tag   = ret_v ? ret_word : tag_q;
    assign idle      = !ret_v && !stall_v;

    always_comb begin
        i_rdy = ret_v && (ret_kind != K_LOW);
        i_dr  = 32'd0;
        if (i_rdy) begin
            i_dr = (ret_kind == K_HIGH) ? {m_dr[15:0], buf_q[31:16]} : m_dr;
        end

        sample = !reset && i_re && (i_rdy || idle);

        new_kind = K_LOW;
        new_word = sample_word;
        if (!i_adr[1]) begin
            new_kind = K_FULL;
        end else if (eff_valid && (eff_tag == sample_word)) begin
            new_kind = K_HIGH;
            new_word = sample_word + WW'(1);
        end

        // Follow-up of a split beats a stalled re-issue, which beats a fresh request.
        iss_v    = 1'b0;
        iss_kind = K_FULL;
        iss_word = '0;
        if (ret_v && (ret_kind == K_LOW)) begin
            iss_v    = 1'b1;
            iss_kind = K_HIGH;
            iss_word = req_word + WW'(1);
        end else if (stall_v) begin
            iss_v    = 1'b1;
            iss_kind = stall_kind;
            iss_word = stall_word;
        end else if (sample) begin
            iss_v    = 1'b1;
            iss_kind = new_kind;
            iss_word = new_word;
        end

        m_re    = iss_v;
        m_adr   = {iss_word, 2'b00};
        n_split = split_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_v      <= 1'b0;
            ret_kind   <= K_FULL;
            ret_word   <= '0;
            stall_v    <= 1'b0;
            stall_kind <= K_FULL;
            stall_word <= '0;
            req_word   <= '0;
            buf_q      <= 32'd0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            split_q    <= 16'd0;
        end else begin
            ret_v      <= iss_v && m_rdy;
            ret_kind   <= iss_kind;
            ret_word   <= iss_word;
            stall_v    <= iss_v && !m_rdy;
            stall_kind <= iss_kind;
            stall_word <= iss_word;
            if (sample) begin
                req_word <= sample_word;
            end
            if (ret_v) begin
                buf_q   <= m_dr;
                tag_q   <= ret_word;
                valid_q <= 1'b1;
            end
            if (sample && (new_kind == K_LOW) && (split_q != 16'hFFFF)) begin
                split_q <= split_q + 16'd1;
            end
        end
    end

endmodule
